// File: rtl/calc1_req_driver.sv
`default_nettype none
// ============================================================================
//  Module   : calc1_req_driver
//  Purpose  : Requester for one calc1 port. Buffers producer commands in a
//             small FIFO, drives each one onto the calc1 request bus
//             (command + operand 1, then operand 2), waits for the port's
//             response and hands response code/data back to the producer.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH    command FIFO entries (power of 2, >= 2)
//    TIMEOUT  WAIT samples before a response is abandoned (>= 2)
//  Optional feature macro
//    CALC1_DRV_TIMEOUT_EN  defined  : wait counter + timeout pulse present
//                          undefined: WAIT exits only on a response,
//                                     timeout tied low, TIMEOUT unused
//  Ports
//    c_clk         in   1   sole clock, rising edge
//    reset         in   1   synchronous, active-low
//    cmd_valid     in   1   producer offers a command
//    cmd_ready     out  1   FIFO not full and reset released
//    cmd_op        in   4   calc1 command code (0 = NOP)
//    cmd_op1       in   32  operand 1
//    cmd_op2       in   32  operand 2
//    req_cmd_out   out  4   to port req_cmd_in
//    req_data_out  out  32  to port req_data_in
//    out_resp      in   2   port response code (0 = none)
//    out_data      in   32  port result
//    rsp_valid     out  1   one-cycle pulse: response captured
//    rsp_code      out  2   last captured response code
//    rsp_data      out  32  last captured response data
//    timeout       out  1   one-cycle pulse: response abandoned
//    busy          out  1   a command is in flight
//    proto_err     out  1   sticky: response seen while not waiting
// ============================================================================
module calc1_req_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_op1,
    input  logic [31:0] cmd_op2,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_code,
    output logic [31:0] rsp_data,
    output logic        timeout,
    output logic        busy,
    output logic        proto_err
);

    localparam int            c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_send2 = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("calc1_req_driver: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
    end

    // FIFO storage is not reset; the pointers/count alone define its contents
    logic [3:0]      r_fifo_op  [DEPTH];
    logic [31:0]     r_fifo_op1 [DEPTH];
    logic [31:0]     r_fifo_op2 [DEPTH];
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw:0]   r_count;

    logic [1:0]  r_state;
    logic [31:0] r_op2;      // operand 2 latched at pop: its slot may be refilled before SEND2
    logic [3:0]  r_req_cmd;
    logic [31:0] r_req_data;
    logic        r_rsp_valid;
    logic [1:0]  r_rsp_code;
    logic [31:0] r_rsp_data;
    logic        r_proto_err;

    logic       w_push;
    logic       w_pop;
    logic       w_issue;
    logic [3:0] w_head_op;
    logic       w_timeout_hit;

    assign cmd_ready = reset && (r_count != c_full);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_head_op = r_fifo_op[r_rd_ptr];
    // NOP heads are popped and dropped in IDLE without touching the bus
    assign w_pop     = (r_state == c_st_idle) && (r_count != '0);
    assign w_issue   = w_pop && (w_head_op != 4'd0);

    always_ff @(posedge c_clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]  <= cmd_op;
            r_fifo_op1[r_wr_ptr] <= cmd_op1;
            r_fifo_op2[r_wr_ptr] <= cmd_op2;
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef CALC1_DRV_TIMEOUT_EN
    localparam int             c_cw   = $clog2(TIMEOUT);
    localparam logic [c_cw-1:0] c_last = c_cw'(TIMEOUT - 1);

    logic [c_cw-1:0] r_wait_cnt;
    logic            r_timeout;

    // Counter holds the number of silent WAIT samples already seen
    assign w_timeout_hit = (r_state == c_st_wait) && (out_resp == 2'd0) && (r_wait_cnt == c_last);
    assign timeout       = r_timeout;

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if (r_state == c_st_send2) begin
                r_wait_cnt <= '0;
            end else if (r_state == c_st_wait && out_resp == 2'd0 && !w_timeout_hit) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            r_state     <= c_st_idle;
            r_op2       <= '0;
            r_req_cmd   <= '0;
            r_req_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= '0;
            r_rsp_data  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (out_resp != 2'd0) r_proto_err <= 1'b1;
                    r_req_cmd  <= '0;
                    r_req_data <= '0;
                    if (w_issue) begin
                        r_req_cmd  <= w_head_op;
                        r_req_data <= r_fifo_op1[r_rd_ptr];
                        r_op2      <= r_fifo_op2[r_rd_ptr];
                        r_state    <= c_st_send2;
                    end
                end
                c_st_send2: begin
                    if (out_resp != 2'd0) r_proto_err <= 1'b1;
                    r_req_cmd  <= '0;
                    r_req_data <= r_op2;
                    r_state    <= c_st_wait;
                end
                c_st_wait: begin
                    r_req_cmd  <= '0;
                    r_req_data <= '0;
                    if (out_resp != 2'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_code  <= out_resp;
                        r_rsp_data  <= out_data;
                        r_state     <= c_st_idle;
                    end else if (w_timeout_hit) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign req_cmd_out  = r_req_cmd;
    assign req_data_out = r_req_data;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_code     = r_rsp_code;
    assign rsp_data     = r_rsp_data;
    assign proto_err    = r_proto_err;
    assign busy         = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_calc1_req_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc1_req_driver
//  Purpose  : Self-checking bench for calc1_req_driver. A transaction-level
//             reference (command queue + in-flight age) predicts every output
//             each cycle; directed scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calc1_req_driver;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
`ifdef CALC1_DRV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        c_clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_op1;
    logic [31:0] cmd_op2;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic        timeout;
    logic        busy;
    logic        proto_err;

    calc1_req_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_op1     (cmd_op1),
        .cmd_op2     (cmd_op2),
        .req_cmd_out (req_cmd_out),
        .req_data_out(req_data_out),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .rsp_valid   (rsp_valid),
        .rsp_code    (rsp_code),
        .rsp_data    (rsp_data),
        .timeout     (timeout),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge c_clk);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
    } ent_t;

    ent_t        q[$];
    ent_t        cur;
    int          age = -1;   // -1: nothing in flight; 0: cmd/op1 on bus; 1: op2 on bus; k>=1 also = WAIT sample index
    logic [3:0]  e_cmd;
    logic [31:0] e_data;
    logic        e_rsp_valid;
    logic [1:0]  e_code;
    logic [31:0] e_rdata;
    logic        e_timeout;
    logic        e_perr;

    always @(posedge c_clk) begin
        bit   do_push;
        ent_t head;
        ent_t pushed;
        do_push = reset && cmd_valid && (q.size() < DEPTH);
        pushed  = '{op: cmd_op, op1: cmd_op1, op2: cmd_op2};
        e_rsp_valid = 1'b0;
        e_timeout   = 1'b0;
        if (!reset) begin
            q.delete();
            age     = -1;
            e_cmd   = '0;
            e_data  = '0;
            e_code  = '0;
            e_rdata = '0;
            e_perr  = 1'b0;
        end else begin
            e_cmd  = '0;
            e_data = '0;
            if (age < 0) begin
                if (out_resp != 2'd0) e_perr = 1'b1;
                if (q.size() > 0) begin
                    head = q.pop_front();
                    if (head.op != 4'd0) begin
                        cur    = head;
                        age    = 0;
                        e_cmd  = head.op;
                        e_data = head.op1;
                    end
                end
            end else if (age == 0) begin
                if (out_resp != 2'd0) e_perr = 1'b1;
                e_data = cur.op2;
                age    = 1;
            end else begin
                if (out_resp != 2'd0) begin
                    e_rsp_valid = 1'b1;
                    e_code      = out_resp;
                    e_rdata     = out_data;
                    age         = -1;
                end else if (TO_EN && age == TIMEOUT) begin
                    e_timeout = 1'b1;
                    age       = -1;
                end else begin
                    age++;
                end
            end
            if (do_push) q.push_back(pushed);
        end
    end

    always @(posedge c_clk) begin
        #1;
        if (chk_en) begin
            chk("m_cmd_ready", cmd_ready, reset && (q.size() < DEPTH));
            chk("m_req_cmd",   req_cmd_out, e_cmd);
            chk("m_req_data",  req_data_out, e_data);
            chk("m_rsp_valid", rsp_valid, e_rsp_valid);
            chk("m_rsp_code",  rsp_code, e_code);
            chk("m_rsp_data",  rsp_data, e_rdata);
            chk("m_timeout",   timeout, e_timeout);
            chk("m_busy",      busy, age >= 0);
            chk("m_proto_err", proto_err, e_perr);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_op1   = a;
        cmd_op2   = b;
        step();
        cmd_valid = 1'b0;
    endtask

    // Waits for the next issue, checks both bus beats, answers after 'dly' silent WAIT samples
    task automatic serve(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] resp, input logic [31:0] data, input int dly);
        int n = 0;
        while (req_cmd_out == 4'd0 && n < 40) begin
            step();
            n++;
        end
        if (req_cmd_out == 4'd0) begin
            n_cmp++;
            n_err++;
            $display("FAIL serve_issue: no command on bus after %0d cycles, expected op 0x%0h", n, op);
        end else begin
            chk("issue_cmd", req_cmd_out, op);
            chk("issue_op1", req_data_out, a);
            step();
            chk("send2_cmd", req_cmd_out, 0);
            chk("send2_op2", req_data_out, b);
            repeat (dly) step();
            out_resp = resp;
            out_data = data;
            step();
            out_resp = 2'd0;
            chk("rsp_valid_hi", rsp_valid, 1);
            chk("rsp_code",     rsp_code, resp);
            chk("rsp_data",     rsp_data, data);
            chk("rsp_idle",     busy, 0);
            step();
            chk("rsp_valid_lo", rsp_valid, 0);
            chk("rsp_code_hold", rsp_code, resp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_op1   = '0;
        cmd_op2   = '0;
        out_resp  = '0;
        out_data  = '0;
        repeat (3) step();
        chk_en = 1'b1;

        // reset state
        chk("rst_cmd",       req_cmd_out, 0);
        chk("rst_data",      req_data_out, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_code",  rsp_code, 0);
        chk("rst_rsp_data",  rsp_data, 0);
        chk("rst_timeout",   timeout, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_ready",     cmd_ready, 0);
        reset = 1'b1;
        step();
        chk("ready_after_rst", cmd_ready, 1);

        // add 5 + 3, answered three cycles after op2
        push(4'd1, 32'h5, 32'h3);
        chk("add_not_yet", busy, 0);
        serve(4'd1, 32'h5, 32'h3, 2'd1, 32'h8, 2);

        // five back-to-back pushes, silent port until the FIFO has filled
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 4'(i + 1);
            cmd_op1   = 32'h100 + 32'(i);
            cmd_op2   = 32'h200 + 32'(i);
            step();
            chk("fill_ready", cmd_ready, (i < 4) ? 1 : 0);
            if (i == 1) begin
                chk("fill_issue_cmd", req_cmd_out, 1);
                chk("fill_issue_op1", req_data_out, 32'h100);
            end
        end
        cmd_valid = 1'b0;
        out_resp  = 2'd1;
        out_data  = 32'hC1;
        step();
        out_resp = 2'd0;
        chk("fill_rsp1_valid", rsp_valid, 1);
        chk("fill_rsp1_data",  rsp_data, 32'hC1);
        for (int i = 1; i < 5; i++) begin
            serve(4'(i + 1), 32'h100 + 32'(i), 32'h200 + 32'(i), 2'd2, 32'hD0 + 32'(i), 1);
        end

`ifdef CALC1_DRV_TIMEOUT_EN
        // silent port: timeout after TIMEOUT WAIT samples, next command after one IDLE cycle
        push(4'd6, 32'h11, 32'h22);
        push(4'd7, 32'h33, 32'h44);
        chk("to_issue", req_cmd_out, 6);
        repeat (15) step();
        chk("to_early", timeout, 0);
        step();
        chk("to_pulse",     timeout, 1);
        chk("to_no_rsp",    rsp_valid, 0);
        chk("to_idle",      busy, 0);
        step();
        chk("to_pulse_end", timeout, 0);
        serve(4'd7, 32'h33, 32'h44, 2'd1, 32'h55, 0);
`endif

        // response while idle sets the sticky protocol error
        step();
        out_resp = 2'd1;
        step();
        out_resp = 2'd0;
        chk("perr_set", proto_err, 1);
        push(4'd2, 32'h9, 32'h4);
        serve(4'd2, 32'h9, 32'h4, 2'd1, 32'h5, 3);
        chk("perr_sticky", proto_err, 1);

        // NOP is consumed silently, then a shift
        push(4'd0, 32'hAA, 32'hBB);
        chk("nop_idle", busy, 0);
        push(4'd5, 32'h1, 32'h4);
        chk("nop_no_bus",  req_cmd_out, 0);
        chk("nop_no_busy", busy, 0);
        serve(4'd5, 32'h1, 32'h4, 2'd1, 32'h10, 1);

        // reset during WAIT with two entries queued
        push(4'd3, 32'h30, 32'h31);
        push(4'd4, 32'h40, 32'h41);
        push(4'd8, 32'h80, 32'h81);
        chk("mid_busy", busy, 1);
        step();
        reset = 1'b0;
        step();
        chk("mid_rst_cmd",   req_cmd_out, 0);
        chk("mid_rst_data",  req_data_out, 0);
        chk("mid_rst_busy",  busy, 0);
        chk("mid_rst_perr",  proto_err, 0);
        reset    = 1'b1;
        out_resp = 2'd1;
        step();
        out_resp = 2'd0;
        chk("late_rsp_perr",  proto_err, 1);
        chk("late_rsp_valid", rsp_valid, 0);
        repeat (3) step();
        chk("flushed_cmd",  req_cmd_out, 0);
        chk("flushed_busy", busy, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom % 300) != 0;
            cmd_valid = ($urandom % 3) == 0;
            cmd_op    = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom);
            cmd_op1   = $urandom;
            cmd_op2   = $urandom;
            out_data  = $urandom;
            if (busy && req_cmd_out == 4'd0 && ($urandom % 6) == 0) out_resp = 2'($urandom_range(3, 1));
            else if (!busy && ($urandom % 150) == 0)                   out_resp = 2'd1;
            else                                                       out_resp = 2'd0;
            step();
        end
        reset     = 1'b1;
        cmd_valid = 1'b0;
        out_resp  = 2'd0;
        for (int c = 0; c < 60 && busy; c++) begin
            out_resp = (req_cmd_out == 4'd0) ? 2'd1 : 2'd0;
            step();
        end
        out_resp = 2'd0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
